// File: rtl/axi_perf_wr_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the axi_perf write
// generator (master) and the memory side (slave).
interface axi_perf_wr_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16,
   parameter int ID_W   = 4
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0]   awid;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic              wlast;
   logic              bvalid;
   logic              bready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast,
      output bready,
      input  awready, wready, bvalid, bid, bresp
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast,
      input  bready,
      output awready, wready, bvalid, bid, bresp
   );
endinterface

// File: rtl/axi_perf_wr.sv
// AXI4 write-burst traffic generator: on start, issues burst_num INCR bursts
// with independent AW and W streams, and counts run cycles and BRESP errors.
module axi_perf_wr #(
   parameter int AXI_ADDR_WIDTH = 20,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [7:0]                burst_beats,
   input  logic [AXI_ADDR_WIDTH-1:0] burst_stride,
   input  logic [2:0]                burst_awsize,
   input  logic [15:0]               burst_num,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               cycles,
   output logic [15:0]               resp_errs,
   axi_perf_wr_if.master             m_axi
);
   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state;
   logic [7:0]    cfg_beats;
   logic [AW-1:0] cfg_stride;
   logic [15:0]   cfg_num;
   logic [AW-1:0] aw_addr;
   logic [7:0]    aw_len;
   logic [2:0]    aw_size;
   logic          aw_valid;
   logic [15:0]   aw_cnt;
   logic          w_valid;
   logic          w_last;
   logic [7:0]    w_beat;
   logic [15:0]   w_burst;
   logic [31:0]   beat_ctr;
   logic          b_ready;
   logic [15:0]   b_cnt;
   logic          aw_fire;
   logic          w_fire;
   logic          b_fire;
   logic          unused_bits;

   assign aw_fire = aw_valid & m_axi.awready;
   assign w_fire  = w_valid & m_axi.wready;
   assign b_fire  = b_ready & m_axi.bvalid;

   assign m_axi.awvalid = aw_valid;
   assign m_axi.awaddr  = aw_addr;
   assign m_axi.awid    = '0;
   assign m_axi.awlen   = aw_len;
   assign m_axi.awsize  = aw_size;
   assign m_axi.awburst = 2'b01;
   assign m_axi.wvalid  = w_valid;
   assign m_axi.wdata   = beat_ctr[DW-1:0];
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = w_last;
   assign m_axi.bready  = b_ready;

   // The slave is trusted, so BID is never checked; beat_ctr is wider than wdata.
   assign unused_bits = ^{m_axi.bid, beat_ctr};

   // NOTE: every register here is a flop with async reset; all updates use <=
   // so each branch sees the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         cycles     <= '0;
         resp_errs  <= '0;
         cfg_beats  <= '0;
         cfg_stride <= '0;
         cfg_num    <= '0;
         aw_addr    <= '0;
         aw_len     <= '0;
         aw_size    <= '0;
         aw_valid   <= 1'b0;
         aw_cnt     <= '0;
         w_valid    <= 1'b0;
         w_last     <= 1'b0;
         w_beat     <= '0;
         w_burst    <= '0;
         beat_ctr   <= '0;
         b_ready    <= 1'b0;
         b_cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cfg_beats  <= burst_beats;
                  cfg_stride <= burst_stride;
                  cfg_num    <= burst_num;
                  aw_addr    <= base_addr;
                  aw_len     <= burst_beats - 8'd1;
                  aw_size    <= burst_awsize;
                  aw_cnt     <= '0;
                  w_beat     <= '0;
                  w_burst    <= '0;
                  w_last     <= (burst_beats == 8'd1);
                  beat_ctr   <= '0;
                  b_cnt      <= '0;
                  resp_errs  <= '0;
                  if (burst_num == 16'd0 || burst_beats == 8'd0) begin
                     // An empty run still reports one cycle of activity.
                     state  <= S_DONE;
                     done   <= 1'b1;
                     cycles <= 32'd1;
                  end else begin
                     state    <= S_RUN;
                     busy     <= 1'b1;
                     b_ready  <= 1'b1;
                     aw_valid <= 1'b1;
                     w_valid  <= 1'b1;
                     cycles   <= '0;
                  end
               end
            end

            S_RUN: begin
               if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;

               if (aw_fire) begin
                  aw_cnt  <= aw_cnt + 16'd1;
                  aw_addr <= aw_addr + cfg_stride;
                  if (aw_cnt == cfg_num - 16'd1) aw_valid <= 1'b0;
               end

               if (w_fire) begin
                  beat_ctr <= beat_ctr + 32'd1;
                  if (w_last) begin
                     w_beat  <= '0;
                     w_last  <= (cfg_beats == 8'd1);
                     w_burst <= w_burst + 16'd1;
                     if (w_burst == cfg_num - 16'd1) w_valid <= 1'b0;
                  end else begin
                     w_beat <= w_beat + 8'd1;
                     w_last <= (w_beat + 8'd2 == cfg_beats);
                  end
               end

               if (b_fire) begin
                  b_cnt <= b_cnt + 16'd1;
                  if (m_axi.bresp != 2'b00 && resp_errs != 16'hFFFF)
                     resp_errs <= resp_errs + 16'd1;
                  // Final response ends the run even if the slave answered early.
                  if (b_cnt == cfg_num - 16'd1) begin
                     state    <= S_DONE;
                     busy     <= 1'b0;
                     b_ready  <= 1'b0;
                     aw_valid <= 1'b0;
                     w_valid  <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end

            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/axi_perf_wr.md
Name: axi_perf_wr

Overview:
AXI4 write-burst traffic generator for the axi_perf design. It consumes the configuration from the control register block (base_addr, burst_beats, burst_stride, burst_awsize, burst_num). On start it issues burst_num INCR write bursts on an AXI master port and counts cycles and error responses for readback.

Parameters:
AXI_ADDR_WIDTH, 20, AXI address width (AW)
AXI_DATA_WIDTH, 16, AXI data width (DW); strobe width DW/8
AXI_ID_WIDTH, 4, AXI ID width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle run request
base_addr  in  AW  address of burst 0
burst_beats  in  8  beats per burst, 1..255
burst_stride  in  AW  byte offset between consecutive burst start addresses
burst_awsize  in  3  AXSIZE for every burst
burst_num  in  16  number of bursts in the run
busy  out  1  run in progress
done  out  1  one-cycle pulse when the run completes
cycles  out  32  cycles of the last or current run
resp_errs  out  16  count of non-OKAY BRESP in the last or current run
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_awaddr  out  AW  AW address
m_axi_awid  out  AXI_ID_WIDTH  AW ID, constant 0
m_axi_awlen  out  8  burst_beats-1
m_axi_awsize  out  3  latched burst_awsize
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_wdata  out  DW  W data
m_axi_wstrb  out  DW/8  constant all ones
m_axi_wlast  out  1  last beat of the burst
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready
m_axi_bid  in  AXI_ID_WIDTH  unused
m_axi_bresp  in  2  B response

Behaviour:
- Reset: busy, done, awvalid, wvalid and bready are 0. cycles, resp_errs and all internal counters are 0. Assertion clears the outputs immediately; an in-flight run is abandoned with no completion. The first start after reset begins a clean run.
- FSM states are IDLE, RUN and DONE.
- IDLE: start=1 latches all config inputs, clears cycles and resp_errs, and enters RUN. Config changes after the latch have no effect until the next start. start outside IDLE is ignored.
- Degenerate run: if burst_num==0 or burst_beats==0 at start, go IDLE→DONE with no AXI traffic. done pulses in the cycle after start.
- RUN: busy=1 and bready=1.
- awvalid and wvalid are registered and first assert in the cycle after start.
- AW channel:
  - Burst k address = base_addr + k*burst_stride, computed by accumulation and truncated mod 2^AW (wraps silently).
  - awvalid stays high, and awaddr stays stable, until awready.
  - The next AW may present in the cycle after a handshake (back-to-back allowed).
  - AW stops after burst_num handshakes.
- W channel:
  - Independent of AW; W may lead or lag AW with any number of bursts outstanding.
  - wdata = low DW bits of a 32-bit running beat counter. The counter starts at 0 for each run and increments on every W handshake across bursts.
  - wlast=1 on beat burst_beats-1 of each burst. The beat counter within a burst wraps to 0 after wlast.
  - wvalid, wdata and wlast stay stable until wready.
  - W stops after burst_num*burst_beats handshakes.
- B channel:
  - Count B handshakes.
  - bresp!=2'b00 increments resp_errs, which saturates at 16'hFFFF.
  - A B beat arriving before its AW/W completes is still counted; the slave is trusted.
- cycles:
  - Increments every cycle in RUN, including the entry cycle.
  - Stops on the cycle of the final (burst_num-th) B handshake, inclusive.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value in DONE and IDLE.
- Final B handshake: RUN→DONE on the next edge, with busy=0, bready=0 and done=1 for one cycle, then DONE→IDLE.
- Counter widths: burst index 16 bits, beats-in-burst 8 bits, total B count 16 bits.

Test Plan:
- Config base=0x100, beats=4, stride=0x20, awsize=1, num=3; AW/W ready tied high → awaddr 0x100, 0x120, 0x140 with awlen=3; wdata 0..11 with wlast on beats 3, 7 and 11; done pulses one cycle after the 3rd B; resp_errs=0.
- Same config with awready low for 5 cycles per burst and wready toggling → awaddr and wdata held stable while stalled; totals unchanged; cycles larger than the unstalled run.
- Slave returns bresp=2'b10 on burst 1 of 3 → resp_errs=1; run completes normally.
- base=0xFFFF0, stride=0x10, num=3 at AW=20 → awaddr 0xFFFF0, 0x00000, 0x00010.
- num=0 → no awvalid or wvalid ever asserted; done pulses one cycle after start; cycles=1. Also: start pulsed during RUN is ignored.
- Deassert rst_n mid-run after 2 of 4 bursts → awvalid, wvalid and busy drop immediately; a new start yields a full fresh run with wdata starting at 0.
